// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the Vedic multiplier datapath.
package vedic_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal slicing: at least one whole slice and no partial slice at the top.
    function automatic bit cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its top bit
// so the last slice can derive signed overflow.
module add_slice
    import vedic_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];
    // The top sum bit is a^b^cin, so cin into the top bit is recovered from it.
    assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice resolved per
// stage, carry registered between stages, valid/ready with a global stall.
module adder_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("adder_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic                          w_en;
    logic [STAGES-1:0]             r_vld;
    logic [STAGES-1:0]             w_vld_in;
    logic [STAGES-1:0]             r_c;
    logic [STAGES-1:0]             w_cin;
    logic [STAGES-1:0]             w_cout;
    logic [STAGES-1:0]             w_cmsb;
    logic [STAGES-1:0][WIDTH-1:0]  r_a;
    logic [STAGES-1:0][WIDTH-1:0]  r_b;
    logic [STAGES-1:0][WIDTH-1:0]  r_sum;
    logic [STAGES-1:0][WIDTH-1:0]  w_a_in;
    logic [STAGES-1:0][WIDTH-1:0]  w_b_in;
    logic [STAGES-1:0][WIDTH-1:0]  w_sum_base;
    logic [STAGES-1:0][WIDTH-1:0]  w_sum_nxt;
    logic [STAGES-1:0][CHUNK-1:0]  w_slice_sum;
    logic                          r_ovf;
    logic                          w_unused;

    assign w_en     = ~r_vld[STAGES-1] | out_ready;
    assign in_ready = w_en;

    // Stage inputs: stage 0 takes the ports (b pre-inverted for subtract), later stages the previous registers.
    always_comb begin
        w_a_in     = {(STAGES*WIDTH){1'b0}};
        w_b_in     = {(STAGES*WIDTH){1'b0}};
        w_sum_base = {(STAGES*WIDTH){1'b0}};
        w_cin      = {STAGES{1'b0}};
        w_vld_in   = {STAGES{1'b0}};
        w_a_in[0]  = a;
        if (sub) begin
            w_b_in[0] = ~b;
        end else begin
            w_b_in[0] = b;
        end
        w_cin[0]    = sub;
        w_vld_in[0] = in_valid & w_en;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k]     = r_a[k-1];
            w_b_in[k]     = r_b[k-1];
            w_sum_base[k] = r_sum[k-1];
            w_cin[k]      = r_c[k-1];
            w_vld_in[k]   = r_vld[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        add_slice #(
            .CHUNK (CHUNK)
        ) u_add_slice (
            .i_a    (w_a_in[g][g*CHUNK +: CHUNK]),
            .i_b    (w_b_in[g][g*CHUNK +: CHUNK]),
            .i_cin  (w_cin[g]),
            .o_sum  (w_slice_sum[g]),
            .o_cout (w_cout[g]),
            .o_cmsb (w_cmsb[g])
        );
    end

    // Merge each stage's newly resolved slice into the partial word travelling down the pipe.
    always_comb begin
        w_sum_nxt = w_sum_base;
        for (int k = 0; k < STAGES; k++) begin
            w_sum_nxt[k][k*CHUNK +: CHUNK] = w_slice_sum[k];
        end
    end

    // Pipeline advance: every stage, valid bit and skew register moves together under the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= {STAGES{1'b0}};
            r_c   <= {STAGES{1'b0}};
            r_a   <= {(STAGES*WIDTH){1'b0}};
            r_b   <= {(STAGES*WIDTH){1'b0}};
            r_sum <= {(STAGES*WIDTH){1'b0}};
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_vld <= w_vld_in;
            r_c   <= w_cout;
            r_a   <= w_a_in;
            r_b   <= w_b_in;
            r_sum <= w_sum_nxt;
            r_ovf <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

    // Last stage's operand skew and the intermediate top-bit carries have no consumer.
    assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1], w_cmsb};

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=16, CHUNK=4) with a result scoreboard.
module tb_adder_pipe;

    localparam int W = 16;
    localparam int C = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = 16'h0000;
    logic [W-1:0] b = 16'h0000;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    bit   last_acc = 1'b0;
    bit   stalled = 1'b0;
    logic [15:0] h_sum;
    logic        h_cout;
    logic        h_ovf;
    exp_t sb[$];

    adder_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Reference: 17-bit sum; overflow when same-signed addends give a differently-signed result.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] full;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, s};
        return mk(full[15:0], full[16], (x[15] == yy[15]) && (full[15] != x[15]));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input bit use_in = 1'b0, input exp_t e_in = '0);
        exp_t e;
        @(negedge clk);
        if (stalled) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_sum", {16'd0, sum}, {16'd0, h_sum});
            chk("hold_flags", {30'd0, cout, ovf}, {30'd0, h_cout, h_ovf});
        end
        stalled = out_valid && !out_ready;
        h_sum   = sum;
        h_cout  = cout;
        h_ovf   = ovf;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                pops++;
                chk("sum", {16'd0, sum}, {16'd0, e.sum});
                chk("cout", {31'd0, cout}, {31'd0, e.cout});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb.push_back(use_in ? e_in : model(a, b, sub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 40 && sb.size() != 0; n++) step();
        chk("drain_empty", sb.size(), 32'd0);
        step();
        step();
    endtask

    logic [15:0] ta [4] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int n;
        int nb;
        int p0;
        int sent;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat: latency and 0x00FF + 1
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
        step(1'b1, mk(16'h0100, 1'b0, 1'b0));
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", n, 32'd4);
        chk("t1_sum", {16'd0, sum}, 32'h0100);
        drain();

        // Carry ripple, signed overflow and subtraction corners, back to back
        for (int i = 0; i < 4; i++) begin
            a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1;
            step(1'b1, mk(es[i], ec[i], eo[i]));
        end
        drain();

        // Back-pressure: 8 beats, out_ready low in cycles 6..8
        p0 = pops;
        nb = 0;
        for (int c = 1; c <= 40 && (nb < 8 || sb.size() != 0); c++) begin
            out_ready = !(c >= 6 && c <= 8);
            in_valid  = (nb < 8);
            a   = 16'(nb);
            b   = 16'(nb) << 12;
            sub = 1'b0;
            #1;
            chk($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, (c >= 6 && c <= 8) ? 32'd0 : 32'd1);
            step();
            if (last_acc) nb++;
        end
        chk("bp_count", pops - p0, 32'd8);
        drain();

        // Random operands with random back-pressure
        sent = 0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(1, 0));
        in_valid = 1'b1;
        for (int c = 0; c < 600 && sent < 24; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            step();
            if (last_acc) begin
                sent++;
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom_range(1, 0));
            end
        end
        chk("rand_sent", sent, 32'd24);
        drain();

        // Reset with three beats in flight (oldest already at the output)
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h1111 * 16'(i + 1); b = 16'h0101; sub = 1'b0;
            step();
        end
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_sum", {16'd0, sum}, 32'd0);
        chk("async_rst_flags", {30'd0, cout, ovf}, 32'd0);
        sb.delete();
        stalled = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        a = 16'h1234; b = 16'h4321; sub = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("post_rst_latency", n, 32'd4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
